act_sched: RTL
==============

// Module: act_sched
// PURPOSE
//  Round-robin scheduler that shares one act_core between NUM_REQ streaming requesters.
//  Locks a grant for a whole packet (through in_last) and programs the core mode over its cfg bus.
//  Rewrites the mode only when it changes and only after the core has drained.
//  Routes core output packets back to the granting requester.
// PARAMETERS
//  NUM_REQ    4    requester count (2..8)
//  AXI_WIDTH  128  beat width, matches act_core
//  TAG_DEPTH  4    packets in flight (route-tag FIFO depth, power of 2)
// PORTS
//  clk            in   1                    clock
//  rst            in   1                    synchronous reset, active-high
//  req_mode       in   2*NUM_REQ            per-requester mode, sampled at grant (0=ReLU, 1=SiLU)
//  s_valid        in   NUM_REQ              requester beat valid
//  s_ready        out  NUM_REQ              requester beat ready
//  s_data         in   NUM_REQ*AXI_WIDTH    requester beats
//  s_last         in   NUM_REQ              requester end of packet
//  core_cfg_wr_en out  1                    act_core cfg strobe
//  core_cfg_addr  out  6                    cfg address, always 6'h30 when strobed
//  core_cfg_wdata out  64                   {62'b0, mode}
//  core_in_valid  out  1                    act_core input valid
//  core_in_ready  in   1                    act_core input ready
//  core_in_data   out  AXI_WIDTH            act_core input beat
//  core_in_last   out  1                    act_core input last
//  core_out_valid in   1                    act_core output valid
//  core_out_ready out  1                    act_core output ready
//  core_out_data  in   AXI_WIDTH            act_core output beat
//  core_out_last  in   1                    act_core output last
//  m_valid        out  NUM_REQ              return beat valid, one-hot or zero
//  m_ready        in   NUM_REQ              return beat ready
//  m_data         out  AXI_WIDTH            return beat, shared bus
//  m_last         out  1                    return end of packet
//  busy           out  1                    FSM not IDLE or tag FIFO not empty
//  grant_id       out  $clog2(NUM_REQ)      current/last granted requester
// BEHAVIOUR
//  Reset: FSM=IDLE, rr_ptr=0, grant_id=0, cur_mode=0, mode_known=0, tag FIFO empty.
//  Reset: all outputs 0.
//  Reset mid-packet discards in-flight state. The core is reset alongside and is not drained.
//  IDLE: if any s_valid and tag FIFO not full, pick the first requester at or after rr_ptr (wrapping).
//    Latch grant_id and g_mode=req_mode[grant_id].
//    Go to STREAM if mode_known && g_mode==cur_mode; otherwise go to DRAIN.
//  DRAIN: wait until tag FIFO empty and !core_out_valid, then go to CFG.
//  CFG: one cycle; core_cfg_wr_en=1, addr 6'h30, wdata=g_mode. Set cur_mode=g_mode, mode_known=1.
//    Go to STREAM.
//  STREAM: core_in_* = s_*[grant_id]; s_ready[grant_id] = core_in_ready; other s_ready = 0.
//    On the first accepted beat, push grant_id into the tag FIFO.
//    On an accepted beat with s_last: rr_ptr = grant_id+1 (mod NUM_REQ), go to IDLE.
//    Every packet gets exactly one push, including single-beat packets.
//  Arbitration overhead: 1 cycle per packet with no mode change. A mode change also costs DRAIN time + 1.
//  Return path: if the tag FIFO is not empty, head = tag.
//    m_valid[head] = core_out_valid; core_out_ready = m_ready[head]; m_data/m_last pass through.
//    Pop the tag on an accepted beat with core_out_last.
//    If the tag FIFO is empty, core_out_ready=0 and m_valid=0.
//  Return path is purely combinational: zero added latency, no beat loss or duplication.
//  Tag FIFO full: IDLE does not grant. A packet already in STREAM continues.
//  Simultaneous push and pop: allowed. Count is unchanged; pointers wrap mod TAG_DEPTH.
//  A requester dropping s_valid mid-packet stalls STREAM. There is no timeout and no preemption.
//  Never strobe cfg while core_in_valid=1 or while beats remain in flight.
// STRUCTURE
//  Package act_pkg: ACT_MODE_RELU=2'd0, ACT_MODE_SILU=2'd1, ACT_CFG_MODE_ADDR=6'h30.
//  Package act_pkg: sched state enum {IDLE, DRAIN, CFG, STREAM}.
//  Sub-module act_tag_fifo: synchronous FIFO, width $clog2(NUM_REQ), depth TAG_DEPTH,
//    with full/empty outputs and simultaneous push/pop.
//  Round-robin pick, FSM and muxes stay inline.
// TESTING
//  1. After reset, req0 sends 3 beats, mode 0 -> one cfg write (6'h30, 0) before the first beat.
//     Core receives 3 beats; m_valid[0] asserts for 3 beats; last on beat 3.
//  2. req1 and req2 valid together, both mode 0, rr_ptr=0 -> req1 granted, then req2.
//     No second cfg write; the grant switches only after req1's last.
//  3. req0 sends mode 0, then req3 sends mode 1 -> DRAIN until req0 output is fully returned.
//     Then exactly one cfg write with wdata=1, then req3's beats.
//  4. TAG_DEPTH=4, m_ready held 0, five 1-beat packets from alternating requesters.
//     Exactly 4 packets are accepted and the 5th gets no s_ready.
//     Releasing m_ready drains them in grant order with correct m_valid one-hot.
//  5. Assert rst mid-STREAM of a 4-beat packet -> next cycle all outputs 0, FIFO empty.
//     The next packet triggers a cfg write (mode_known cleared).
//  6. Random valid/ready (seeded) on all requesters -> every returned packet matches
//     act_core's transform of its source, in order, with no cfg strobe while in flight.

Source files
------------

// File: rtl/act_pkg.sv
// Shared constants and types for the activation-core scheduler.
package act_pkg;

    localparam logic [1:0] ACT_MODE_RELU     = 2'd0;
    localparam logic [1:0] ACT_MODE_SILU     = 2'd1;
    localparam logic [5:0] ACT_CFG_MODE_ADDR = 6'h30;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CFG,
        STREAM
    } sched_state_e;

endpackage

// File: rtl/act_tag_fifo.sv
// Route-tag FIFO: remembers which requester owns each packet inside the core.
module act_tag_fifo
    import act_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q];

    // Next pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage; contents are meaningless while the count says empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/act_sched.sv
// Round-robin scheduler sharing one act_core between NUM_REQ packet streams.
module act_sched
    import act_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int AXI_WIDTH = 128,
    parameter int TAG_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2*NUM_REQ-1:0]         req_mode,
    input  logic [NUM_REQ-1:0]           s_valid,
    output logic [NUM_REQ-1:0]           s_ready,
    input  logic [NUM_REQ*AXI_WIDTH-1:0] s_data,
    input  logic [NUM_REQ-1:0]           s_last,
    output logic                         core_cfg_wr_en,
    output logic [5:0]                   core_cfg_addr,
    output logic [63:0]                  core_cfg_wdata,
    output logic                         core_in_valid,
    input  logic                         core_in_ready,
    output logic [AXI_WIDTH-1:0]         core_in_data,
    output logic                         core_in_last,
    input  logic                         core_out_valid,
    output logic                         core_out_ready,
    input  logic [AXI_WIDTH-1:0]         core_out_data,
    input  logic                         core_out_last,
    output logic [NUM_REQ-1:0]           m_valid,
    input  logic [NUM_REQ-1:0]           m_ready,
    output logic [AXI_WIDTH-1:0]         m_data,
    output logic                         m_last,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

    localparam int ID_W = $clog2(NUM_REQ);

    sched_state_e    state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [1:0]      g_mode_q, g_mode_d;
    logic [1:0]      cur_mode_q, cur_mode_d;
    logic            mode_known_q, mode_known_d;
    logic            first_q, first_d;

    logic            pick_found;
    logic [ID_W-1:0] pick_id;
    logic            sel_valid;
    logic            sel_last;
    logic            beat_acc;
    logic            tag_push;
    logic            tag_pop;
    logic [ID_W-1:0] tag_head;
    logic            tag_full;
    logic            tag_empty;

    act_tag_fifo #(
        .WIDTH (ID_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tag_push),
        .push_data (grant_id_q),
        .pop       (tag_pop),
        .pop_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    assign sel_valid = s_valid[grant_id_q];
    assign sel_last  = s_last[grant_id_q];
    assign busy      = (state_q != IDLE) || !tag_empty;
    assign grant_id  = grant_id_q;

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!pick_found && s_valid[idx]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    // Scheduler FSM next state plus the input-side and cfg muxes.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_id_d     = grant_id_q;
        g_mode_d       = g_mode_q;
        cur_mode_d     = cur_mode_q;
        mode_known_d   = mode_known_q;
        first_d        = first_q;
        s_ready        = '0;
        core_in_valid  = 1'b0;
        core_in_data   = '0;
        core_in_last   = 1'b0;
        core_cfg_wr_en = 1'b0;
        core_cfg_addr  = '0;
        core_cfg_wdata = '0;
        tag_push       = 1'b0;
        beat_acc       = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found && !tag_full) begin
                    grant_id_d = pick_id;
                    g_mode_d   = req_mode[pick_id*2 +: 2];
                    first_d    = 1'b1;
                    if (mode_known_q && (g_mode_d == cur_mode_q)) begin
                        state_d = STREAM;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The mode register may only change once nothing is left inside the core.
                if (tag_empty && !core_out_valid) begin
                    state_d = CFG;
                end
            end
            CFG: begin
                core_cfg_wr_en = 1'b1;
                core_cfg_addr  = ACT_CFG_MODE_ADDR;
                core_cfg_wdata = {62'b0, g_mode_q};
                cur_mode_d     = g_mode_q;
                mode_known_d   = 1'b1;
                state_d        = STREAM;
            end
            STREAM: begin
                core_in_valid        = sel_valid;
                core_in_data         = s_data[grant_id_q*AXI_WIDTH +: AXI_WIDTH];
                core_in_last         = sel_last;
                s_ready[grant_id_q]  = core_in_ready;
                beat_acc             = sel_valid && core_in_ready;
                if (beat_acc) begin
                    // One tag per packet, taken on its first accepted beat.
                    tag_push = first_q;
                    first_d  = 1'b0;
                    if (sel_last) begin
                        rr_ptr_d = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Return path: the tag at the FIFO head owns the current core output packet.
    always_comb begin
        m_valid        = '0;
        core_out_ready = 1'b0;
        m_data         = '0;
        m_last         = 1'b0;
        if (!tag_empty) begin
            m_valid[tag_head] = core_out_valid;
            core_out_ready    = m_ready[tag_head];
            m_data            = core_out_data;
            m_last            = core_out_last;
        end
    end

    assign tag_pop = core_out_valid && core_out_ready && core_out_last;

    // Scheduler registers; reset forgets the current core mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_id_q   <= '0;
            g_mode_q     <= ACT_MODE_RELU;
            cur_mode_q   <= ACT_MODE_RELU;
            mode_known_q <= 1'b0;
            first_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            g_mode_q     <= g_mode_d;
            cur_mode_q   <= cur_mode_d;
            mode_known_q <= mode_known_d;
            first_q      <= first_d;
        end
    end

endmodule
